eth_tx_pkt_fifo: RTL

ETH_TX_PKT_FIFO -- requirements
Module: eth_tx_pkt_fifo

---
 rtl/eth_tx_pkt_fifo.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/eth_tx_pkt_fifo.sv
// Ethernet transmit packet FIFO between the packet source and the MAC.
// Supports store-and-forward and cut-through modes, with overflow dropping and framing-error counting.
module eth_tx_pkt_fifo #(
  parameter int DATA_W      = 64,
  parameter int MOD_W       = 3,
  parameter int DEPTH       = 256,
  parameter int FULL_THRESH = 4
) (
  input  logic                   clk156m25,
  input  logic                   reset_156m25,
  input  logic                   cfg_store_fwd,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [MOD_W-1:0]       in_mod,
  input  logic                   in_val,
  output logic                   in_full,
  output logic [DATA_W-1:0]      pkt_tx_data,
  output logic                   pkt_tx_sop,
  output logic                   pkt_tx_eop,
  output logic [MOD_W-1:0]       pkt_tx_mod,
  output logic                   pkt_tx_val,
  input  logic                   pkt_tx_full,
  output logic                   drop_pulse,
  output logic [15:0]            err_cnt,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = DATA_W + MOD_W + 2;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   lvl_t;
  typedef enum logic [1:0] {ST_IDLE, ST_IN_PKT, ST_DISCARD} wr_state_e;

  wr_state_e         state_q, state_d;
  logic [EW-1:0]     mem_q [DEPTH];
  ptr_t              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, start_q, start_d;
  ptr_t              wr_addr, pkt_words;
  lvl_t              level_q, level_d, pkt_cnt_q, pkt_cnt_d, rewind_n;
  logic              mode_q, rd_mid_q, rd_mid_d, in_full_q, drop_q, drop_d;
  logic [15:0]       err_q, err_d;
  logic              wr_en, wr_eop, rewind, err_inc, take, room, last_slot;
  logic              rd_en, eligible;
  logic [MOD_W-1:0]  wr_mod;
  logic [EW-1:0]     head;
  logic              head_sop, head_eop;
  logic [MOD_W-1:0]  head_mod;
  logic [DATA_W-1:0] head_data;

  assign head = mem_q[rd_ptr_q];
  assign {head_sop, head_eop, head_mod, head_data} = head;

  // Usable capacity is DEPTH-1 words; the top usable word is the forced-eop reserve.
  assign room      = level_q < lvl_t'(DEPTH - 2);
  assign last_slot = level_q == lvl_t'(DEPTH - 2);

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_addr = wr_ptr_q;
    wr_eop  = in_eop;
    wr_mod  = in_mod;
    rewind  = 1'b0;
    drop_d  = 1'b0;
    err_inc = 1'b0;
    take    = 1'b0;
    if (in_val) begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_sop) take = 1'b1;
          else        err_inc = 1'b1;
        end
        ST_IN_PKT: begin
          if (in_sop) begin
            err_inc = 1'b1;
            if (mode_q) begin
              rewind  = 1'b1;
              wr_en   = 1'b1;
              wr_addr = start_q;
              state_d = in_eop ? ST_IDLE : ST_IN_PKT;
            end else begin
              take = 1'b1;
            end
          end else begin
            take = 1'b1;
          end
        end
        ST_DISCARD: begin
          if (in_sop)      take = 1'b1;
          else if (in_eop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (take) begin
      if (room) begin
        wr_en   = 1'b1;
        state_d = in_eop ? ST_IDLE : ST_IN_PKT;
      end else begin
        drop_d  = 1'b1;
        state_d = ST_DISCARD;
        if (mode_q) begin
          rewind = (state_q == ST_IN_PKT);
        end else if (last_slot) begin
          wr_en  = 1'b1;
          wr_eop = 1'b1;
          wr_mod = '0;
        end
      end
    end
  end

  always_comb begin
    pkt_words = wr_ptr_q - start_q;
    rewind_n  = rewind ? {1'b0, pkt_words} : '0;
    wr_ptr_d  = rewind ? start_q : wr_ptr_q;
    if (wr_en) wr_ptr_d = wr_addr + ptr_t'(1);
    start_d   = (wr_en && in_sop) ? wr_addr : start_q;

    eligible  = (level_q != '0) && (!mode_q || (pkt_cnt_q != '0) || rd_mid_q);
    rd_en     = eligible && !pkt_tx_full && !reset_156m25;
    rd_ptr_d  = rd_en ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    rd_mid_d  = rd_en ? !head_eop : rd_mid_q;

    level_d   = level_q - rewind_n + lvl_t'(wr_en) - lvl_t'(rd_en);
    pkt_cnt_d = pkt_cnt_q + lvl_t'(wr_en & wr_eop) - lvl_t'(rd_en & head_eop);
    err_d     = (err_inc && err_q != '1) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge clk156m25) begin
    if (wr_en) mem_q[wr_addr] <= {in_sop, wr_eop, wr_mod, in_data};
  end

  always_ff @(posedge clk156m25) begin
    if (reset_156m25) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      start_q   <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      rd_mid_q  <= 1'b0;
      in_full_q <= 1'b0;
      drop_q    <= 1'b0;
      err_q     <= '0;
      mode_q    <= cfg_store_fwd;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      start_q   <= start_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      rd_mid_q  <= rd_mid_d;
      in_full_q <= int'(level_d) + FULL_THRESH > DEPTH - 1;
      drop_q    <= drop_d;
      err_q     <= err_d;
      if (level_q == '0 && state_q == ST_IDLE && !rd_mid_q) mode_q <= cfg_store_fwd;
    end
  end

  assign pkt_tx_val  = rd_en;
  assign pkt_tx_data = head_data;
  assign pkt_tx_sop  = head_sop & ~reset_156m25;
  assign pkt_tx_eop  = head_eop & ~reset_156m25;
  assign pkt_tx_mod  = head_mod;
  assign in_full     = in_full_q & ~reset_156m25;
  assign drop_pulse  = drop_q & ~reset_156m25;
  assign err_cnt     = err_q;
  assign level       = level_q;
endmodule
